seed_frame_tx: RTL and testbench



---
 rtl/seed_frame_tx.sv | 129 ++++++++++++
 tb/tb_seed_frame_tx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/seed_frame_tx.sv
// seed_frame_tx: sends the captured local seed pair as SYNC/X/Y bytes over a valid/ready byte link.
// Build option SEED_FRAME_CHECKSUM_EN appends an XOR checksum byte (SYNC^X^Y) to every frame.
module seed_frame_tx #(
    parameter logic [7:0] SYNC_BYTE  = 8'hA5,
    parameter int         REPEAT     = 2,
    parameter int         GAP_CYCLES = 16
) (
    input  logic       clk_75,
    input  logic       rst,
    input  logic [4:0] seed_x_in,
    input  logic [4:0] seed_y_in,
    input  logic       seed_rdy,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       busy,
    output logic       done
);
    localparam logic [3:0]  LAST_FRAME = 4'(REPEAT - 1);
    localparam logic [15:0] GAP_LAST   = 16'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {IDLE, SYNC, X, Y, CSUM, GAP, FINISH} state_t;

    state_t      state;
    logic        seed_rdy_q;
    logic [3:0]  frame_cnt;
    logic [15:0] gap_cnt;
    logic [4:0]  x_cap;
    logic [4:0]  y_cap;
    logic        trigger;
    logic        last_accept;
    logic [7:0]  x_byte;
    logic [7:0]  y_byte;

    assign trigger = seed_rdy & ~seed_rdy_q;
    assign x_byte  = {3'b010, x_cap};
    assign y_byte  = {3'b011, y_cap};

`ifdef SEED_FRAME_CHECKSUM_EN
    function automatic logic [7:0] frame_csum(input logic [7:0] xb, input logic [7:0] yb);
        return SYNC_BYTE ^ xb ^ yb;
    endfunction

    assign last_accept = (state == CSUM) && tx_ready;
`else
    assign last_accept = (state == Y) && tx_ready;
`endif

    always_ff @(posedge clk_75) begin
        // Sampled through reset so a level held across reset is not taken as a new request.
        seed_rdy_q <= seed_rdy;
        if (rst) begin
            state     <= IDLE;
            tx_valid  <= 1'b0;
            tx_data   <= 8'h00;
            busy      <= 1'b0;
            done      <= 1'b0;
            frame_cnt <= 4'd0;
            gap_cnt   <= 16'd0;
            x_cap     <= 5'd0;
            y_cap     <= 5'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        x_cap     <= seed_x_in;
                        y_cap     <= seed_y_in;
                        frame_cnt <= 4'd0;
                        state     <= SYNC;
                        busy      <= 1'b1;
                        tx_valid  <= 1'b1;
                        tx_data   <= SYNC_BYTE;
                    end
                end
                SYNC: begin
                    if (tx_ready) begin
                        tx_data <= x_byte;
                        state   <= X;
                    end
                end
                X: begin
                    if (tx_ready) begin
                        tx_data <= y_byte;
                        state   <= Y;
                    end
                end
`ifdef SEED_FRAME_CHECKSUM_EN
                Y: begin
                    if (tx_ready) begin
                        tx_data <= frame_csum(x_byte, y_byte);
                        state   <= CSUM;
                    end
                end
`endif
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state    <= SYNC;
                        tx_valid <= 1'b1;
                        tx_data  <= SYNC_BYTE;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                FINISH: state <= IDLE;
                default: ;
            endcase
            // Final byte of a frame accepted: repeat the frame or wrap up.
            if (last_accept) begin
                if (frame_cnt == LAST_FRAME) begin
                    state    <= FINISH;
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                end else begin
                    frame_cnt <= frame_cnt + 4'd1;
                    gap_cnt   <= 16'd0;
                    if (GAP_CYCLES == 0) begin
                        state   <= SYNC;
                        tx_data <= SYNC_BYTE;
                    end else begin
                        state    <= GAP;
                        tx_valid <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_seed_frame_tx.sv
// Bench for seed_frame_tx: dut1 sends one frame per trigger, dut2 two frames with a 16-cycle gap.
// Expected bytes are queued by the stimulus and consumed by a negedge monitor on every transfer.
module tb_seed_frame_tx;
    localparam logic [7:0] SYNC = 8'hA5;
    localparam int GAP = 16;
`ifdef SEED_FRAME_CHECKSUM_EN
    localparam int NB = 4;
`else
    localparam int NB = 3;
`endif

    logic       clk_75 = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] seed_x_in = 5'd0;
    logic [4:0] seed_y_in = 5'd0;
    logic       rdy1 = 1'b0;
    logic       rdy2 = 1'b0;
    logic       tx_ready = 1'b1;
    logic [7:0] data1, data2;
    logic       vld1, vld2, busy1, busy2, done1, done2;

    int checks = 0;
    int passes = 0;
    int done_cnt1 = 0;
    int done_cnt2 = 0;
    int gap_run2 = 0;
    logic [7:0] q1[$];
    logic [7:0] q2[$];

    always #5 clk_75 = ~clk_75;

    seed_frame_tx #(.SYNC_BYTE(8'hA5), .REPEAT(1), .GAP_CYCLES(GAP)) dut1 (
        .clk_75(clk_75), .rst(rst), .seed_x_in(seed_x_in), .seed_y_in(seed_y_in),
        .seed_rdy(rdy1), .tx_ready(tx_ready), .tx_data(data1), .tx_valid(vld1),
        .busy(busy1), .done(done1));

    seed_frame_tx #(.SYNC_BYTE(8'hA5), .REPEAT(2), .GAP_CYCLES(GAP)) dut2 (
        .clk_75(clk_75), .rst(rst), .seed_x_in(seed_x_in), .seed_y_in(seed_y_in),
        .seed_rdy(rdy2), .tx_ready(tx_ready), .tx_data(data2), .tx_valid(vld2),
        .busy(busy2), .done(done2));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_75);
        #1;
    endtask

    task automatic push(input int which, input logic [7:0] xb, input logic [7:0] yb,
                        input logic [7:0] cs);
        logic [7:0] fr[4];
        fr[0] = SYNC; fr[1] = xb; fr[2] = yb; fr[3] = cs;
        for (int i = 0; i < NB; i++) begin
            if (which == 1) q1.push_back(fr[i]);
            else q2.push_back(fr[i]);
        end
    endtask

    task automatic wait_done(input int which, input int bound, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            tick();
            seen = (which == 1) ? done1 : done2;
        end
        check(name, 32'(seen), 32'd1);
    endtask

    // Scoreboard monitor: byte order, stall stability, gap length, done bookkeeping.
    initial begin
        logic       stall1 = 1'b0, stall2 = 1'b0;
        logic [7:0] hold1 = 8'h00, hold2 = 8'h00;
        logic [7:0] e;
        forever begin
            @(negedge clk_75);
            if (stall1) check("dut1_stall_hold", {23'd0, vld1, data1}, {23'd0, 1'b1, hold1});
            if (stall2) check("dut2_stall_hold", {23'd0, vld2, data2}, {23'd0, 1'b1, hold2});
            stall1 = vld1 && !tx_ready && !rst;
            stall2 = vld2 && !tx_ready && !rst;
            hold1 = data1;
            hold2 = data2;
            if (vld1 && tx_ready && !rst) begin
                if (q1.size() == 0) check("dut1_unexpected_byte", 32'(data1), 32'hFFFF_FFFF);
                else begin e = q1.pop_front(); check("dut1_byte", 32'(data1), 32'(e)); end
            end
            if (vld2 && tx_ready && !rst) begin
                if (q2.size() == 0) check("dut2_unexpected_byte", 32'(data2), 32'hFFFF_FFFF);
                else begin e = q2.pop_front(); check("dut2_byte", 32'(data2), 32'(e)); end
            end
            if (done1) begin
                done_cnt1++;
                check("dut1_done_all_sent", 32'(q1.size()), 32'd0);
                check("dut1_done_busy_low", 32'(busy1), 32'd0);
            end
            if (done2) begin
                done_cnt2++;
                check("dut2_done_all_sent", 32'(q2.size()), 32'd0);
                check("dut2_done_busy_low", 32'(busy2), 32'd0);
            end
            if (rst) gap_run2 = 0;
            else if (busy2 && !vld2) gap_run2++;
            else if (busy2 && vld2 && gap_run2 > 0) begin
                check("dut2_gap_len", 32'(gap_run2), 32'(GAP));
                gap_run2 = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
        $fatal(1);
    end

    initial begin
        int d0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_valid1", 32'(vld1), 32'd0);
        check("rst_data1", 32'(data1), 32'h00);
        check("rst_busy1", 32'(busy1), 32'd0);
        check("rst_done1", 32'(done1), 32'd0);
        check("rst_valid2", 32'(vld2), 32'd0);
        check("rst_busy2", 32'(busy2), 32'd0);
        tick();

        // Single frame, x=7 y=12, ready tied high: latency and done width.
        seed_x_in = 5'd7; seed_y_in = 5'd12;
        push(1, 8'h47, 8'h6C, 8'h8E);
        rdy1 = 1'b1;
        tick();
        check("sync_first_valid", 32'(vld1), 32'd1);
        check("sync_first_data", 32'(data1), 32'(SYNC));
        check("sync_first_busy", 32'(busy1), 32'd1);
        repeat (NB) tick();
        check("done_latency", 32'(done1), 32'd1);
        check("done_latency_busy", 32'(busy1), 32'd0);
        tick();
        check("done_one_cycle", 32'(done1), 32'd0);
        check("idle_valid_low", 32'(vld1), 32'd0);
        rdy1 = 1'b0;
        repeat (3) tick();
        check("t1_done_count", 32'(done_cnt1), 32'd1);

        // Two frames x=3 y=22 separated by the gap.
        seed_x_in = 5'd3; seed_y_in = 5'd22;
        push(2, 8'h43, 8'h76, 8'h90);
        push(2, 8'h43, 8'h76, 8'h90);
        rdy2 = 1'b1;
        tick();
        wait_done(2, 200, "t2_done_seen");
        rdy2 = 1'b0;
        repeat (3) tick();
        check("t2_queue_empty", 32'(q2.size()), 32'd0);
        check("t2_done_count", 32'(done_cnt2), 32'd1);

        // Stall on the X byte while the seed inputs change.
        seed_x_in = 5'd9; seed_y_in = 5'd1;
        push(1, 8'h49, 8'h61, 8'h8D);
        rdy1 = 1'b1;
        tick();
        tick();
        tx_ready = 1'b0;
        seed_x_in = 5'd30; seed_y_in = 5'd2;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_x_valid", 32'(vld1), 32'd1);
            check("stall_x_data", 32'(data1), 32'h49);
        end
        tx_ready = 1'b1;
        wait_done(1, 50, "t3_done_seen");
        rdy1 = 1'b0;
        repeat (3) tick();
        check("t3_queue_empty", 32'(q1.size()), 32'd0);

        // Reset while the Y byte is presented, with seed_rdy held high across it.
        seed_x_in = 5'd7; seed_y_in = 5'd12;
        q2.push_back(SYNC); q2.push_back(8'h47);
        rdy2 = 1'b1;
        tick();
        tick();
        tick();
        check("abort_y_presented", 32'(data2), 32'h6C);
        rst = 1'b1; tx_ready = 1'b0;
        tick();
        check("abort_valid_low", 32'(vld2), 32'd0);
        check("abort_busy_low", 32'(busy2), 32'd0);
        rst = 1'b0; tx_ready = 1'b1;
        check("abort_bytes_sent", 32'(q2.size()), 32'd0);
        d0 = done_cnt2;
        repeat (10) tick();
        check("held_rdy_no_restart", 32'(busy2), 32'd0);
        check("abort_no_done", 32'(done_cnt2), 32'(d0));
        rdy2 = 1'b0;
        tick();
        push(2, 8'h47, 8'h6C, 8'h8E);
        push(2, 8'h47, 8'h6C, 8'h8E);
        rdy2 = 1'b1;
        tick();
        wait_done(2, 200, "t4_done_seen");
        rdy2 = 1'b0;
        repeat (3) tick();
        check("t4_queue_empty", 32'(q2.size()), 32'd0);

        // Re-triggers while busy are dropped; x=31 passes through raw.
        seed_x_in = 5'd31; seed_y_in = 5'd0;
        push(2, 8'h5F, 8'h60, 8'h9A);
        push(2, 8'h5F, 8'h60, 8'h9A);
        d0 = done_cnt2;
        rdy2 = 1'b1;
        tick(); tick();
        rdy2 = 1'b0;
        tick();
        rdy2 = 1'b1;
        tick();
        rdy2 = 1'b0;
        repeat (8) tick();
        rdy2 = 1'b1;
        tick();
        rdy2 = 1'b0;
        wait_done(2, 200, "t5_done_seen");
        repeat (10) tick();
        check("t5_single_done", 32'(done_cnt2), 32'(d0 + 1));
        check("t5_queue_empty", 32'(q2.size()), 32'd0);
        check("t5_idle_busy", 32'(busy2), 32'd0);
        check("t5_idle_valid", 32'(vld2), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
